io_engine_scheduler: RTL
========================

IO_ENGINE_SCHEDULER -- requirements
Module: io_engine_scheduler

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 1023, maximum cycles allowed in ACTIVE before an engine is forcibly released (range 1..1023, 10-bit timer).
REQ-002 CLOCK_50  in  1  sole clock; all state updates on rising edge.
REQ-003 resetIn  in  1  reset, asynchronous, active-low.
REQ-004 req  in  3  level requests from CPU side; bit0 = writeToRam engine, bit1 = drawToVGA engine, bit2 = saveToLowRam engine.
REQ-005 done  out  3  per-requester acknowledge, four-phase.
REQ-006 eng_en  out  3  enable to each engine; at most one bit high at any time.
REQ-007 eng_ack  in  3  acknowledge from each engine.
REQ-008 addr_w, addr_d, addr_s  in  11 each  engine RAM addresses.
REQ-009 we_w, we_s  in  1 each  engine RAM write enables; draw engine has none.
REQ-010 data_w, data_s  in  32 each  engine RAM write data.
REQ-011 ram_addr  out  11; ram_data  out  32; ram_we  out  1  shared RAM port.
REQ-012 busy  out  1  high in any state other than IDLE.
REQ-013 grant_id  out  2  index of current grant; 2'b11 when none.
REQ-014 timeout_err  out  1  sticky timeout flag; err_clr  in  1  synchronous clear.

Function
REQ-015 FSM states IDLE, ACTIVE, RELEASE, DONE; all outputs registered or decoded from registered state.
REQ-016 IDLE: if any req bit high, select next requester round-robin starting at (last_grant+1) mod 3, load grant, clear timer, go ACTIVE; no requests -> stay IDLE.
REQ-017 Latency: req rising in cycle N -> eng_en[g] high in cycle N+1.
REQ-018 ACTIVE: eng_en[g]=1; timer increments each cycle; eng_ack[g]=1 -> RELEASE next cycle; timer reaching TIMEOUT_CYCLES with eng_ack[g]=0 -> RELEASE and set timeout_err.
REQ-019 RELEASE: eng_en all 0; eng_ack[g]=0 -> DONE; otherwise stay (no timeout in RELEASE).
REQ-020 DONE: done[g]=1; req[g]=0 -> IDLE with last_grant<=g; req[g] still high -> stay in DONE.
REQ-021 done bits other than done[g] held 0 always; done[g] low outside DONE.
REQ-022 RAM mux in ACTIVE: g=0 -> addr_w/data_w/we_w; g=1 -> addr_d, data 0, we 0; g=2 -> addr_s/data_s/we_s.
REQ-023 RAM mux in IDLE, RELEASE, DONE: ram_addr=0, ram_data=0, ram_we=0.
REQ-024 eng_ack on non-granted engine ignored in all states.
REQ-025 req[g] dropped during ACTIVE/RELEASE: transaction completes normally; DONE lasts exactly one cycle.
REQ-026 New requests arriving during a transaction wait; no preemption.
REQ-027 timeout_err: set and err_clr same cycle -> set wins; otherwise err_clr clears.
REQ-028 Timer stops at TIMEOUT_CYCLES, no wrap.

Reset
REQ-029 resetIn low asynchronously forces IDLE, eng_en=0, done=0, ram_we=0, ram_addr=0, ram_data=0, busy=0, grant_id=2'b11, timeout_err=0, timer=0.
REQ-030 last_grant resets to 2 so the first arbitration favours bit0.
REQ-031 Reset mid-ACTIVE drops eng_en immediately; no done issued for the aborted transaction.

Verification
REQ-032 req=3'b001, eng_ack[0] returned 5 cycles after eng_en -> eng_en=001 at N+1, ram_we follows we_w, done[0] high until req[0] drops, busy low after.
REQ-033 req=3'b111 held from reset -> grant order 0,1,2,0; eng_en never multi-hot.
REQ-034 TIMEOUT_CYCLES=8, eng_ack never asserted -> eng_en drops after 8 ACTIVE cycles, timeout_err=1 until err_clr pulse.
REQ-035 Grant draw (g=1) with we_w=1, we_s=1 -> ram_we=0, ram_addr=addr_d, ram_data=0.
REQ-036 resetIn low during ACTIVE -> all outputs zero within same cycle, grant_id=2'b11, req0 after release granted first.
REQ-037 req[2] dropped during ACTIVE -> done[2] high exactly one cycle, then IDLE.

Source files
------------

// File: rtl/io_engine_scheduler_if.sv
// Bus between the CPU/engine side and the IO engine scheduler: requests,
// engine handshakes, per-engine RAM ports and the shared RAM port.
interface io_engine_scheduler_if;
    logic [2:0]  req;
    logic [2:0]  done;
    logic [2:0]  eng_en;
    logic [2:0]  eng_ack;
    logic [10:0] addr_w;
    logic [10:0] addr_d;
    logic [10:0] addr_s;
    logic        we_w;
    logic        we_s;
    logic [31:0] data_w;
    logic [31:0] data_s;
    logic [10:0] ram_addr;
    logic [31:0] ram_data;
    logic        ram_we;
    logic        busy;
    logic [1:0]  grant_id;
    logic        timeout_err;
    logic        err_clr;

    modport master (
        output req, eng_ack, addr_w, addr_d, addr_s, we_w, we_s, data_w, data_s, err_clr,
        input  done, eng_en, ram_addr, ram_data, ram_we, busy, grant_id, timeout_err
    );

    modport slave (
        input  req, eng_ack, addr_w, addr_d, addr_s, we_w, we_s, data_w, data_s, err_clr,
        output done, eng_en, ram_addr, ram_data, ram_we, busy, grant_id, timeout_err
    );
endinterface

// File: rtl/io_engine_scheduler.sv
// Round-robin scheduler granting one of three IO engines the shared RAM port,
// with a four-phase done handshake back to the requester and an ACTIVE timeout.
//
// state   | meaning
// IDLE    | no grant; arbitrate among pending requests
// ACTIVE  | engine enabled and owns the RAM port; timer running
// RELEASE | engine disabled; waiting for its ack to fall
// DONE    | done[g] raised; waiting for req[g] to fall
module io_engine_scheduler #(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input logic                  CLOCK_50,
    input logic                  resetIn,
    io_engine_scheduler_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        RELEASE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [9:0] TIMER_LAST = 10'(TIMEOUT_CYCLES - 1);
    localparam logic [9:0] TIMER_MAX  = 10'(TIMEOUT_CYCLES);

    state_t     state;
    state_t     nextState;
    logic [1:0] grant;
    logic [1:0] lastGrant;
    logic [1:0] pick;
    logic [2:0] grantHot;
    logic [9:0] timer;
    logic       timeoutErr;
    logic       anyReq;
    logic       ackG;
    logic       reqG;
    logic       timeoutHit;

    assign grantHot   = 3'b001 << grant;
    assign anyReq     = |bus.req;
    assign ackG       = |(bus.eng_ack & grantHot);
    assign reqG       = |(bus.req & grantHot);
    assign timeoutHit = (state == ACTIVE) && !ackG && (timer == TIMER_LAST);

    // Search starts one past the last served engine so nobody starves.
    always_comb begin
        pick = 2'd0;
        case (lastGrant)
            2'd0:    pick = bus.req[1] ? 2'd1 : (bus.req[2] ? 2'd2 : 2'd0);
            2'd1:    pick = bus.req[2] ? 2'd2 : (bus.req[0] ? 2'd0 : 2'd1);
            default: pick = bus.req[0] ? 2'd0 : (bus.req[1] ? 2'd1 : 2'd2);
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetIn) begin
        if (!resetIn) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (anyReq) nextState = ACTIVE;
            ACTIVE:  if (ackG || timeoutHit) nextState = RELEASE;
            RELEASE: if (!ackG) nextState = DONE;
            DONE:    if (!reqG) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetIn) begin
        if (!resetIn) begin
            grant      <= 2'd0;
            lastGrant  <= 2'd2;
            timer      <= '0;
            timeoutErr <= 1'b0;
        end else begin
            if (state == IDLE && anyReq) begin
                grant <= pick;
                timer <= '0;
            end else if (state == ACTIVE && timer != TIMER_MAX) begin
                timer <= timer + 10'd1;
            end
            if (state == DONE && !reqG) begin
                lastGrant <= grant;
            end
            if (timeoutHit) begin
                timeoutErr <= 1'b1;
            end else if (bus.err_clr) begin
                timeoutErr <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.eng_en      = (state == ACTIVE) ? grantHot : 3'b000;
        bus.done        = (state == DONE) ? grantHot : 3'b000;
        bus.busy        = (state != IDLE);
        bus.grant_id    = (state == IDLE) ? 2'b11 : grant;
        bus.timeout_err = timeoutErr;
        bus.ram_addr    = '0;
        bus.ram_data    = '0;
        bus.ram_we      = 1'b0;
        // The draw engine only reads, so its data and write enable stay low.
        if (state == ACTIVE) begin
            case (grant)
                2'd0: begin
                    bus.ram_addr = bus.addr_w;
                    bus.ram_data = bus.data_w;
                    bus.ram_we   = bus.we_w;
                end
                2'd1: bus.ram_addr = bus.addr_d;
                2'd2: begin
                    bus.ram_addr = bus.addr_s;
                    bus.ram_data = bus.data_s;
                    bus.ram_we   = bus.we_s;
                end
                default: ;
            endcase
        end
    end
endmodule
